// File: rtl/lockout_timer.sv
// Countdown lockout timer: loads a seconds count, decrements on each 1 Hz tick edge, pulses done on expiry.
// Latency: a tick_in rise sampled at edge k moves sec_left at edge k+1; start/cancel act on the next edge.
// Backpressure: none; start, cancel and tick_in are level-sampled every cycle and never stalled.
module lockout_timer #(
  parameter int MAX_SEC = 99
) (
  input  logic       clk_ht,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       start,
  input  logic [7:0] load_sec,
  input  logic       cancel,
  output logic       busy,
  output logic       done,
  output logic [7:0] sec_left,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  localparam logic [7:0] MAX_LOAD = 8'(MAX_SEC);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] sec_nxt;
  logic [7:0] load_clamped;
  logic       t1;
  logic       t2;
  logic       tick_armed;
  logic       tick_rise;

  // Two-stage sampler for tick_in; tick_armed only sets once tick_in has been
  // seen low after reset, so a tick already high at release is not a rise.
  always_ff @(posedge clk_ht) begin
    if (reset) begin
      t1         <= 1'b0;
      t2         <= 1'b0;
      tick_armed <= 1'b0;
    end else begin
      t1 <= tick_in;
      t2 <= t1;
      if (!tick_in) begin
        tick_armed <= 1'b1;
      end
    end
  end

  assign tick_rise    = t1 & ~t2 & tick_armed;
  assign load_clamped = (load_sec > MAX_LOAD) ? MAX_LOAD : load_sec;

  // State and remaining-seconds registers.
  always_ff @(posedge clk_ht) begin
    if (reset) begin
      state    <= IDLE;
      sec_left <= 8'd0;
    end else begin
      state    <= state_nxt;
      sec_left <= sec_nxt;
    end
  end

  // Next-state logic: cancel beats start, start beats a same-cycle tick.
  always_comb begin
    state_nxt = state;
    sec_nxt   = sec_left;
    if (cancel) begin
      state_nxt = IDLE;
      sec_nxt   = 8'd0;
    end else begin
      case (state)
        IDLE, EXPIRE: begin
          if (start) begin
            if (load_sec == 8'd0) begin
              state_nxt = EXPIRE;
              sec_nxt   = 8'd0;
            end else begin
              state_nxt = RUN;
              sec_nxt   = load_clamped;
            end
          end else if (state == EXPIRE) begin
            state_nxt = IDLE;
          end
        end
        RUN: begin
          if (start) begin
            if (load_sec == 8'd0) begin
              state_nxt = EXPIRE;
              sec_nxt   = 8'd0;
            end else begin
              sec_nxt = load_clamped;
            end
          end else if (tick_rise) begin
            if (sec_left > 8'd1) begin
              sec_nxt = sec_left - 8'd1;
            end else begin
              state_nxt = EXPIRE;
              sec_nxt   = 8'd0;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          sec_nxt   = 8'd0;
        end
      endcase
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == EXPIRE);
  // sec_left never exceeds 99, so both digits stay within 0..9.
  assign sec_tens = 4'(sec_left / 8'd10);
  assign sec_ones = 4'(sec_left % 8'd10);

endmodule

// File: tb/tb_lockout_timer.sv
// Bench for lockout_timer: directed scenarios plus random traffic, scored against a seconds-level model.
// Each stimulus cycle pushes the expected outputs; a negedge monitor pops and compares.
// Scenario-level checks count done/busy cycles seen by the monitor.
module tb_lockout_timer;

  logic       clk_ht = 1'b0;
  logic       reset;
  logic       tick_in;
  logic       start;
  logic [7:0] load_sec;
  logic       cancel;
  logic       busy;
  logic       done;
  logic [7:0] sec_left;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;

  lockout_timer #(.MAX_SEC(99)) dut (
    .clk_ht   (clk_ht),
    .reset    (reset),
    .tick_in  (tick_in),
    .start    (start),
    .load_sec (load_sec),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .sec_left (sec_left),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones)
  );

  always #5 clk_ht = ~clk_ht;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] sec;
    logic [3:0] tens;
    logic [3:0] ones;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_EXPIRE} mphase_t;

  exp_t    exp_q[$];
  exp_t    mon_e;
  int      n_cmp = 0;
  int      n_bad = 0;
  int      dut_done_cnt = 0;
  int      dut_busy_cnt = 0;

  // Reference model: what the timer is doing, in seconds, plus recent tick samples.
  mphase_t m_phase = M_IDLE;
  int      m_sec = 0;
  int      m_samples[$];
  int      tick_cnt = 0;
  int      tick_mode = 0;   // 0 periodic 20 cycles, 1 held high, 2 held low, 3 random
  logic    tick_rand = 1'b0;

  // A new second begins when the last two post-reset samples read low then high.
  function automatic bit model_rise();
    int n;
    n = m_samples.size();
    return (n >= 2) && (m_samples[n-1] == 1) && (m_samples[n-2] == 0);
  endfunction

  task automatic step(input logic r, input logic s, input logic c, input int ld);
    logic tk;
    bit   rise;
    int   clamp;
    exp_t e;
    case (tick_mode)
      0: tk = ((tick_cnt % 20) >= 10);
      1: tk = 1'b1;
      2: tk = 1'b0;
      default: begin
        if ($urandom_range(4) == 0) tick_rand = ~tick_rand;
        tk = tick_rand;
      end
    endcase
    tick_cnt++;
    reset    = r;
    start    = s;
    cancel   = c;
    load_sec = 8'(ld);
    tick_in  = tk;
    if (r) begin
      m_phase = M_IDLE;
      m_sec   = 0;
      m_samples.delete();
    end else begin
      rise = model_rise();
      m_samples.push_back(tk ? 1 : 0);
      if (m_samples.size() > 3) void'(m_samples.pop_front());
      clamp = (ld > 99) ? 99 : ld;
      if (c) begin
        m_phase = M_IDLE;
        m_sec   = 0;
      end else if (s) begin
        if (ld == 0) begin
          m_phase = M_EXPIRE;
          m_sec   = 0;
        end else begin
          m_phase = M_RUN;
          m_sec   = clamp;
        end
      end else if (m_phase == M_RUN && rise) begin
        m_sec = m_sec - 1;
        if (m_sec == 0) m_phase = M_EXPIRE;
      end else if (m_phase == M_EXPIRE) begin
        m_phase = M_IDLE;
      end
    end
    e.busy = (m_phase == M_RUN);
    e.done = (m_phase == M_EXPIRE);
    e.sec  = 8'(m_sec);
    e.tens = 4'(m_sec / 10);
    e.ones = 4'(m_sec % 10);
    exp_q.push_back(e);
    @(posedge clk_ht);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic settle();
    @(negedge clk_ht);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, expv);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s wait expired got=timeout expected=event", nm);
  endtask

  // Monitor: outputs are valid every cycle, so one expected entry is consumed per negedge.
  always @(negedge clk_ht) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if ({busy, done, sec_left, sec_tens, sec_ones} !== mon_e) begin
        n_bad++;
        $display("FAIL outputs t=%0t got busy=%0b done=%0b sec=%0d tens=%0d ones=%0d expected busy=%0b done=%0b sec=%0d tens=%0d ones=%0d",
                 $time, busy, done, sec_left, sec_tens, sec_ones,
                 mon_e.busy, mon_e.done, mon_e.sec, mon_e.tens, mon_e.ones);
      end
      if (done) dut_done_cnt++;
      if (busy) dut_busy_cnt++;
    end
  end

  initial begin
    int d0;
    int b0;
    int n;

    // Reset state.
    tick_mode = 0;
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 5);
    step(1'b1, 1'b0, 1'b1, 0);
    idle(25);

    // Load 3 and run to expiry with a 20-cycle tick.
    d0 = dut_done_cnt;
    step(1'b0, 1'b1, 1'b0, 3);
    idle(80);
    settle();
    chk("load3_done_pulses", dut_done_cnt - d0, 1);
    chk("load3_busy_after", int'(busy), 0);

    // Clamp above MAX_SEC, then one tick.
    step(1'b0, 1'b1, 1'b0, 150);
    idle(25);
    step(1'b0, 1'b1, 1'b0, 99);
    step(1'b0, 1'b1, 1'b0, 100);
    step(1'b0, 1'b0, 1'b1, 0);
    idle(3);

    // Zero load: immediate done, no run phase.
    settle();
    d0 = dut_done_cnt;
    b0 = dut_busy_cnt;
    step(1'b0, 1'b1, 1'b0, 0);
    idle(5);
    settle();
    chk("load0_done_pulses", dut_done_cnt - d0, 1);
    chk("load0_busy_cycles", dut_busy_cnt - b0, 0);

    // Cancel beats start at sec_left=5; then start on a tick cycle from IDLE and from RUN.
    d0 = dut_done_cnt;
    step(1'b0, 1'b1, 1'b0, 5);
    step(1'b0, 1'b1, 1'b1, 9);
    idle(4);
    settle();
    chk("cancel_done_pulses", dut_done_cnt - d0, 0);
    n = 0;
    while (!model_rise() && n < 40) begin idle(1); n++; end
    if (n >= 40) timeout("rise_idle");
    step(1'b0, 1'b1, 1'b0, 7);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 9);
    n = 0;
    while (!model_rise() && n < 40) begin idle(1); n++; end
    if (n >= 40) timeout("rise_run");
    step(1'b0, 1'b1, 1'b0, 7);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 0);

    // Reset mid-run at sec_left=2 with tick held high; no tick until it goes low again.
    step(1'b0, 1'b1, 1'b0, 3);
    n = 0;
    while (!(m_phase == M_RUN && m_sec == 2) && n < 80) begin idle(1); n++; end
    if (n >= 80) timeout("reach_sec2");
    tick_mode = 1;
    d0 = dut_done_cnt;
    step(1'b1, 1'b0, 1'b0, 0);
    idle(20);
    settle();
    chk("reset_no_done", dut_done_cnt - d0, 0);
    step(1'b0, 1'b1, 1'b0, 5);
    idle(15);
    settle();
    chk("held_high_sec", int'(sec_left), 5);
    tick_mode = 0;
    idle(45);

    // Restart accepted in the EXPIRE cycle.
    step(1'b0, 1'b1, 1'b0, 1);
    n = 0;
    while (m_phase != M_EXPIRE && n < 40) begin idle(1); n++; end
    if (n >= 40) timeout("reach_expire");
    step(1'b0, 1'b1, 1'b0, 4);
    settle();
    chk("expire_restart_busy", int'(busy), 1);
    chk("expire_restart_sec", int'(sec_left), 4);
    idle(10);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) tick_mode = (tick_mode == 3) ? 0 : 3;
      step(($urandom_range(299) == 0), ($urandom_range(24) == 0), ($urandom_range(59) == 0),
           ($urandom_range(7) == 0) ? 0 : int'($urandom_range(160)));
    end

    settle();
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
